// File: rtl/bmu_pkg.sv
// Shared types and encodings for the BMU issue front end: the BMU control
// struct, RV32 opcode/funct constants and the issue FSM state enum.
package bmu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_ROT    = 7'b0110000;
  localparam logic [6:0] F7_BIT    = 7'b0100100;
  localparam logic [6:0] F7_MINMAX = 7'b0000101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [11:0] F12_GORC  = 12'h287;
  localparam logic [11:0] F12_CLZ   = 12'h600;
  localparam logic [11:0] F12_CPOP  = 12'h602;
  localparam logic [11:0] F12_SEXTH = 12'h605;

  typedef struct packed {
    logic csr_write;
    logic csr_imm;
    logic zbb;
    logic zbp;
    logic zba;
    logic zbs;
    logic land;
    logic lxor;
    logic sll;
    logic sra;
    logic rol;
    logic bext;
    logic sh3add;
    logic add;
    logic slt;
    logic unsign;
    logic sub;
    logic clz;
    logic cpop;
    logic siext_h;
    logic min;
    logic packu;
    logic gorc;
  } bmu_ap_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bmu_issue_state_e;

endpackage

// File: rtl/bmu_decode.sv
// Combinational RV32 OP / OP-IMM decoder producing the BMU control struct,
// a legality flag and whether the second operand comes from the immediate.
module bmu_decode
  import bmu_pkg::*;
(
  input  logic [31:0] i_instr,
  output bmu_ap_t     o_ap,
  output logic        o_legal,
  output logic        o_use_imm
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [11:0] w_f12;
  logic        w_unused_fields;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_f12    = i_instr[31:20];
  // Register specifiers play no part in selecting the BMU operation.
  assign w_unused_fields = ^{i_instr[19:15], i_instr[11:7]};

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    o_ap      = '0;
    o_legal   = 1'b0;
    o_use_imm = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        o_legal = 1'b1;
        case ({w_f7, w_f3})
          {F7_BASE,   F3_ADD}:  o_ap.add  = 1'b1;
          {F7_BASE,   F3_AND}:  o_ap.land = 1'b1;
          {F7_ALT,    F3_AND}:  begin o_ap.land = 1'b1; o_ap.zbb = 1'b1; end
          {F7_BASE,   F3_XOR}:  o_ap.lxor = 1'b1;
          {F7_ALT,    F3_XOR}:  begin o_ap.lxor = 1'b1; o_ap.zbb = 1'b1; end
          {F7_BASE,   F3_SLL}:  o_ap.sll  = 1'b1;
          {F7_ALT,    F3_SR}:   o_ap.sra  = 1'b1;
          {F7_ROT,    F3_SLL}:  o_ap.rol  = 1'b1;
          {F7_BIT,    F3_SR}:   o_ap.bext = 1'b1;
          {F7_BASE,   F3_SLT}:  o_ap.slt  = 1'b1;
          {F7_BASE,   F3_SLTU}: begin o_ap.slt = 1'b1; o_ap.unsign = 1'b1; end
          {F7_MINMAX, F3_XOR}:  begin o_ap.min = 1'b1; o_ap.sub = 1'b1; end
          {F7_BIT,    F3_XOR}:  o_ap.packu = 1'b1;
          default:              o_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        o_legal   = 1'b1;
        o_use_imm = 1'b1;
        if (w_f3 == F3_SLL && w_f7 == F7_BASE)           o_ap.sll     = 1'b1;
        else if (w_f3 == F3_SR && w_f7 == F7_ALT)        o_ap.sra     = 1'b1;
        else if (w_f3 == F3_SR && w_f12 == F12_GORC)     o_ap.gorc    = 1'b1;
        else if (w_f3 == F3_SLL && w_f12 == F12_CLZ)     o_ap.clz     = 1'b1;
        else if (w_f3 == F3_SLL && w_f12 == F12_CPOP)    o_ap.cpop    = 1'b1;
        else if (w_f3 == F3_SLL && w_f12 == F12_SEXTH)   o_ap.siext_h = 1'b1;
        else begin
          o_legal   = 1'b0;
          o_use_imm = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bmu_issue.sv
// BMU initiator: accepts an instruction plus operands, issues one BMU op,
// captures the registered result and returns it with the request tag.
// Optional perf counters are built when BMU_ISSUE_PERF_EN is defined.
module bmu_issue
  import bmu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_instr,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             bmu_valid_in,
  output logic [31:0]      bmu_a_in,
  output logic [31:0]      bmu_b_in,
  output logic [22:0]      bmu_ap,
  input  logic [31:0]      bmu_result_ff,
  input  logic             bmu_error
`ifdef BMU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_errors
`endif
);

  bmu_issue_state_e r_state;
  bmu_issue_state_e w_state_nxt;

  bmu_ap_t          r_ap;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_result;
  logic             r_error;

  bmu_ap_t          w_dec_ap;
  logic             w_dec_legal;
  logic             w_dec_use_imm;
  logic             w_zero_b;
  logic [31:0]      w_b;
  logic             w_accept;

  bmu_decode u_decode (
    .i_instr   (req_instr),
    .o_ap      (w_dec_ap),
    .o_legal   (w_dec_legal),
    .o_use_imm (w_dec_use_imm)
  );

  // Unary immediate ops carry a selector in imm[4:0], not an operand.
  assign w_zero_b = w_dec_ap.clz | w_dec_ap.cpop | w_dec_ap.siext_h;
  assign w_b      = !w_dec_use_imm ? req_rs2 :
                    w_zero_b       ? 32'd0   : {27'd0, req_instr[24:20]};
  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    bmu_valid_in = 1'b0;
    bmu_a_in     = '0;
    bmu_b_in     = '0;
    bmu_ap       = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_dec_legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        bmu_valid_in = 1'b1;
        bmu_a_in     = r_a;
        bmu_b_in     = r_b;
        bmu_ap       = r_ap;
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: w_state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ap     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ap     <= w_dec_ap;
        r_a      <= req_rs1;
        r_b      <= w_b;
        r_tag    <= req_tag;
        r_result <= '0;
        r_error  <= !w_dec_legal;
      end
      // The BMU result register is valid in the cycle after valid_in.
      if (r_state == ST_WAIT) begin
        r_result <= bmu_result_ff;
        r_error  <= bmu_error;
      end
    end
  end

  assign rsp_result = r_result;
  assign rsp_error  = r_error;
  assign rsp_tag    = r_tag;

`ifdef BMU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_errors;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_issued <= '0;
      r_perf_errors <= '0;
    end else begin
      if (r_state == ST_ISSUE)
        r_perf_issued <= r_perf_issued + 32'd1;
      if (r_state == ST_RESP && rsp_ready && r_error)
        r_perf_errors <= r_perf_errors + 32'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_errors = r_perf_errors;
`endif

endmodule

// File: tb/tb_bmu_issue.sv
// Self-checking bench for bmu_issue: table-driven decode reference, a
// behavioural BMU stand-in, directed cases and randomized transactions.
module tb_bmu_issue;
  import bmu_pkg::*;

  localparam int TAG_W = 4;
  localparam logic [31:0] M_R = 32'hFE00707F;
  localparam logic [31:0] M_I = 32'hFFF0707F;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_instr;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  logic             bmu_valid_in;
  logic [31:0]      bmu_a_in;
  logic [31:0]      bmu_b_in;
  logic [22:0]      bmu_ap;
  logic [31:0]      bmu_result_ff = '0;
  logic             bmu_error = 1'b0;
`ifdef BMU_ISSUE_PERF_EN
  logic [31:0]      perf_issued;
  logic [31:0]      perf_errors;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit err_inj  = 1'b0;
  int exp_issued = 0;
  int exp_errors = 0;

  always #5 clk = ~clk;

  bmu_issue #(.TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_instr     (req_instr),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_tag       (req_tag),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_error     (rsp_error),
    .rsp_tag       (rsp_tag),
    .bmu_valid_in  (bmu_valid_in),
    .bmu_a_in      (bmu_a_in),
    .bmu_b_in      (bmu_b_in),
    .bmu_ap        (bmu_ap),
    .bmu_result_ff (bmu_result_ff),
    .bmu_error     (bmu_error)
`ifdef BMU_ISSUE_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_errors   (perf_errors)
`endif
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Architectural semantics of each BMU operation.
  function automatic logic [31:0] alu_ref(input bmu_ap_t ap, input logic [31:0] a, input logic [31:0] b);
    int s = int'(b[4:0]);
    logic [31:0] r;
    if (ap.add)  return a + b;
    if (ap.land) return ap.zbb ? (a & ~b) : (a & b);
    if (ap.lxor) return ap.zbb ? ~(a ^ b) : (a ^ b);
    if (ap.sll)  return a << s;
    if (ap.sra)  return $signed(a) >>> s;
    if (ap.rol)  return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
    if (ap.bext) return (a >> s) & 32'd1;
    if (ap.slt)  return ap.unsign ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
    if (ap.min)  return ($signed(a) < $signed(b)) ? a : b;
    if (ap.packu) return {b[31:16], a[31:16]};
    if (ap.clz) begin
      for (int i = 31; i >= 0; i--) if (a[i]) return 31 - i;
      return 32;
    end
    if (ap.cpop) return $countones(a);
    if (ap.siext_h) return {{16{a[15]}}, a[15:0]};
    if (ap.gorc) begin
      r = a;
      if (b[0]) r = r | ((r & 32'h55555555) << 1)  | ((r & 32'hAAAAAAAA) >> 1);
      if (b[1]) r = r | ((r & 32'h33333333) << 2)  | ((r & 32'hCCCCCCCC) >> 2);
      if (b[2]) r = r | ((r & 32'h0F0F0F0F) << 4)  | ((r & 32'hF0F0F0F0) >> 4);
      if (b[3]) r = r | ((r & 32'h00FF00FF) << 8)  | ((r & 32'hFF00FF00) >> 8);
      if (b[4]) r = r | ((r & 32'h0000FFFF) << 16) | ((r & 32'hFFFF0000) >> 16);
      return r;
    end
    return 32'd0;
  endfunction

  // Stand-in BMU: registers its result; scribbles when not issued to.
  always @(posedge clk) begin
    if (bmu_valid_in) begin
      bmu_result_ff <= alu_ref(bmu_ap_t'(bmu_ap), bmu_a_in, bmu_b_in);
      bmu_error     <= err_inj;
    end else begin
      bmu_result_ff <= $urandom;
      bmu_error     <= 1'($urandom);
    end
  end

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    bmu_ap_t     ap;
    bit          imm;
    bit          zero_b;
  } enc_t;
  enc_t enc_q[$];

  task automatic add_enc(input logic [31:0] mask, input logic [31:0] match,
                         input bit imm, input bit zero_b, input bmu_ap_t ap);
    enc_t e;
    e.mask = mask; e.match = match; e.ap = ap; e.imm = imm; e.zero_b = zero_b;
    enc_q.push_back(e);
  endtask

  task automatic build_table();
    bmu_ap_t a;
    a = '0; a.add = 1;                 add_enc(M_R, 32'h00000033, 0, 0, a);
    a = '0; a.land = 1;                add_enc(M_R, 32'h00007033, 0, 0, a);
    a = '0; a.land = 1; a.zbb = 1;     add_enc(M_R, 32'h40007033, 0, 0, a);
    a = '0; a.lxor = 1;                add_enc(M_R, 32'h00004033, 0, 0, a);
    a = '0; a.lxor = 1; a.zbb = 1;     add_enc(M_R, 32'h40004033, 0, 0, a);
    a = '0; a.sll = 1;                 add_enc(M_R, 32'h00001033, 0, 0, a);
    a = '0; a.sra = 1;                 add_enc(M_R, 32'h40005033, 0, 0, a);
    a = '0; a.rol = 1;                 add_enc(M_R, 32'h60001033, 0, 0, a);
    a = '0; a.bext = 1;                add_enc(M_R, 32'h48005033, 0, 0, a);
    a = '0; a.slt = 1;                 add_enc(M_R, 32'h00002033, 0, 0, a);
    a = '0; a.slt = 1; a.unsign = 1;   add_enc(M_R, 32'h00003033, 0, 0, a);
    a = '0; a.min = 1; a.sub = 1;      add_enc(M_R, 32'h0A004033, 0, 0, a);
    a = '0; a.packu = 1;               add_enc(M_R, 32'h48004033, 0, 0, a);
    a = '0; a.sll = 1;                 add_enc(M_R, 32'h00001013, 1, 0, a);
    a = '0; a.sra = 1;                 add_enc(M_R, 32'h40005013, 1, 0, a);
    a = '0; a.gorc = 1;                add_enc(M_I, 32'h28705013, 1, 0, a);
    a = '0; a.clz = 1;                 add_enc(M_I, 32'h60001013, 1, 1, a);
    a = '0; a.cpop = 1;                add_enc(M_I, 32'h60201013, 1, 1, a);
    a = '0; a.siext_h = 1;             add_enc(M_I, 32'h60501013, 1, 1, a);
  endtask

  task automatic ref_decode(input logic [31:0] instr, input logic [31:0] rs2,
                            output bit legal, output bmu_ap_t ap, output logic [31:0] b);
    legal = 0; ap = '0; b = '0;
    foreach (enc_q[i]) begin
      if ((instr & enc_q[i].mask) == enc_q[i].match) begin
        legal = 1;
        ap    = enc_q[i].ap;
        b     = !enc_q[i].imm ? rs2 : enc_q[i].zero_b ? 32'd0 : {27'd0, instr[24:20]};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [TAG_W-1:0] tag, input bit einj, input int stall);
    bit          legal;
    bmu_ap_t     eap;
    logic [31:0] eb;
    logic [31:0] eres;
    bit          eerr;
    int          n;
    ref_decode(instr, rs2, legal, eap, eb);
    eres = legal ? alu_ref(eap, rs1, eb) : 32'd0;
    eerr = legal ? einj : 1'b1;

    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("idle_req_ready", req_ready, 1);
    req_valid = 1; req_instr = instr; req_rs1 = rs1; req_rs2 = rs2; req_tag = tag;
    err_inj = einj;
    tick();
    req_valid = 0; req_instr = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
    if (legal) begin
      check("issue_valid", bmu_valid_in, 1);
      check("issue_a", bmu_a_in, rs1);
      check("issue_b", bmu_b_in, eb);
      check("issue_ap", bmu_ap, eap);
      check("issue_rsp_valid", rsp_valid, 0);
      check("issue_req_ready", req_ready, 0);
      exp_issued++;
      tick();
      check("wait_drive", {bmu_valid_in, bmu_a_in, bmu_b_in, bmu_ap}, 0);
      check("wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_result", rsp_result, eres);
    check("rsp_error", rsp_error, eerr);
    check("rsp_tag", rsp_tag, tag);
    check("rsp_bmu_idle", bmu_valid_in, 0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1; req_tag = TAG_W'($urandom); req_instr = 32'h00000033;
      tick();
      check("stall_hold", {rsp_valid, rsp_error, rsp_tag, rsp_result}, {1'b1, eerr, tag, eres});
      check("stall_req_ready", req_ready, 0);
    end
    rsp_ready = 1; req_valid = 0;
    tick();
    rsp_ready = 0;
    if (eerr) exp_errors++;
    check("post_hs_req_ready", req_ready, 1);
    check("post_hs_rsp_valid", rsp_valid, 0);
  endtask

  task automatic reset_mid_wait();
    req_valid = 1; req_instr = 32'h00B50533; req_rs1 = 32'd1; req_rs2 = 32'd2; req_tag = 4'd9;
    tick();
    req_valid = 0;
    tick();
    check("rstw_in_wait", rsp_valid | bmu_valid_in, 0);
    rst = 1;
    tick();
    rst = 0;
    exp_issued = 0; exp_errors = 0;
    check("rstw_rsp_valid", rsp_valid, 0);
    check("rstw_req_ready", req_ready, 1);
    check("rstw_bmu_valid", bmu_valid_in, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstw_no_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    int          pick;
    build_table();
    rst = 1; req_valid = 0; req_instr = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    check("rst_req_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_error, rsp_tag, rsp_result}, 0);
    check("rst_bmu", {bmu_valid_in, bmu_a_in, bmu_b_in, bmu_ap}, 0);

    run_txn(32'h00B50533, 32'd5, 32'd7, 4'd1, 0, 0);
    run_txn(32'h40B57533, 32'hFFFF00FF, 32'h000000F0, 4'd2, 0, 0);
    run_txn(32'h28755513, 32'h00100001, 32'hDEADBEEF, 4'd4, 0, 0);
    run_txn(32'h00000000, 32'd1, 32'd2, 4'd3, 0, 0);
    run_txn(32'h00B50533, 32'd100, 32'd23, 4'd5, 1, 5);
    run_txn(32'h20B56533, 32'd1, 32'd2, 4'd6, 0, 1);
    run_txn(32'h60201513, 32'hF0F0_0001, 32'd77, 4'd7, 0, 0);
    reset_mid_wait();

    for (int t = 0; t < 160; t++) begin
      pick = $urandom_range(0, 9);
      if (pick < 7) begin
        enc_t e;
        e = enc_q[$urandom_range(0, enc_q.size() - 1)];
        instr = e.match | (32'($urandom) & ~e.mask);
      end else begin
        instr = $urandom;
      end
      run_txn(instr, $urandom, $urandom, TAG_W'($urandom), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 2));
    end

`ifdef BMU_ISSUE_PERF_EN
    check("perf_issued", perf_issued, 32'(exp_issued));
    check("perf_errors", perf_errors, 32'(exp_errors));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bmu_issue.md
Name: bmu_issue

Overview:
- Initiator side of the BMU operand/control interface.
- Accepts RV32 Zb*/base ALU instruction words plus register operands over a valid/ready request channel.
- Decodes each instruction into the BMU `ap` control struct and drives `valid_in` for exactly one cycle.
- Captures the registered `result_ff`/`error` one cycle later and returns them with a tag over a valid/ready response channel. One operation is in flight at a time.

Parameters:
- TAG_W, 4: width of the request/response tag.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only in IDLE
- req_instr  in  32  RV32 instruction word
- req_rs1  in  32  rs1 value
- req_rs2  in  32  rs2 value
- req_tag  in  TAG_W  request tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_result  out  32  result
- rsp_error  out  1  1 = illegal instruction or BMU error
- rsp_tag  out  TAG_W  tag of the originating request
- bmu_valid_in  out  1  to BMU `valid_in`
- bmu_a_in  out  32  to BMU `a_in`
- bmu_b_in  out  32  to BMU `b_in`
- bmu_ap  out  23  to BMU `ap` (bmu_ap_t)
- bmu_result_ff  in  32  from BMU `result_ff`
- bmu_error  in  1  from BMU `error`

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM=IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch instr, rs1, rs2 and tag, and decode.
  - Legal instruction -> ISSUE.
  - Illegal instruction -> RESP with result=0, error=1. BMU is never driven.
- ISSUE:
  - bmu_valid_in=1 for exactly one cycle.
  - bmu_a_in=rs1.
  - bmu_b_in=rs2 (OP) or zero-extended imm[4:0] (OP-IMM).
  - bmu_ap=decoded.
  - -> WAIT.
- WAIT:
  - bmu_valid_in=0; bmu_a_in, bmu_b_in and bmu_ap are driven to 0.
  - bmu_result_ff/bmu_error are captured into the response registers at the end of this cycle.
  - -> RESP.
- RESP:
  - rsp_valid=1; rsp_result, rsp_error and rsp_tag are held stable until rsp_ready.
  - On handshake -> IDLE; req_ready=1 the following cycle.
- BMU drive signals are 0 outside ISSUE.
- Latency from the accept edge to rsp_valid: legal instruction 3 cycles, illegal 1 cycle. Minimum period between accepts: 4 cycles (legal), 2 cycles (illegal).
- Decode, opcode 0110011 (OP), by funct7/funct3:
  - 0000000/000 add
  - 0000000/111 land
  - 0100000/111 land+zbb (andn)
  - 0000000/100 lxor
  - 0100000/100 lxor+zbb (xnor)
  - 0000000/001 sll
  - 0100000/101 sra
  - 0110000/001 rol
  - 0100100/101 bext
  - 0000000/010 slt
  - 0000000/011 slt+unsign
  - 0000101/100 min+sub
  - 0100100/100 packu
- Decode, opcode 0010011 (OP-IMM):
  - f3=001, imm[11:5]=0 -> sll
  - f3=101, imm[11:5]=0100000 -> sra
  - f3=101, imm[11:0]=0x287 -> gorc (b_in=7)
  - f3=001, imm=0x600 -> clz
  - f3=001, imm=0x602 -> cpop
  - f3=001, imm=0x605 -> siext_h
  - For clz, cpop and siext_h, b_in=0.
- Any other encoding, including sh3add, is illegal.
- Reset mid-operation: the FSM returns to IDLE at once, rsp_valid=0 and bmu_valid_in=0; the pending operation is dropped with no response.
- A request presented while not in IDLE is not accepted; req_ready=0.

Optional Feature:
- Macro: BMU_ISSUE_PERF_EN.
- Defined: adds outputs perf_issued[31:0] (increments on each ISSUE cycle) and perf_errors[31:0] (increments on each RESP handshake with rsp_error=1). Both counters wrap at 2^32, are cleared by rst, and are not otherwise resettable.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- bmu_pkg holds:
  - bmu_ap_t packed struct, with field order: csr_write, csr_imm, zbb, zbp, zba, zbs, land, lxor, sll, sra, rol, bext, sh3add, add, slt, unsign, sub, clz, cpop, siext_h, min, packu, gorc.
  - OPC_OP and OPC_OP_IMM constants.
  - funct7/funct12 constants.
  - the bmu_issue_state_e enum.
- Sub-module bmu_decode: purely combinational, instr -> {ap, legal, use_imm}.

Test Plan:
- Instr 0x00B50533 (add), rs1=5, rs2=7 -> bmu_ap has only add set; bmu_valid_in high for one cycle; rsp_result=12, rsp_error=0; rsp_valid 3 cycles after accept.
- Instr 0x40B57533 (andn), rs1=0xFFFF00FF, rs2=0x000000F0 -> bmu_ap land+zbb; rsp_result=0xFFFF000F.
- Instr 0x28755513 (orc.b), rs1=0x00100001 -> bmu_b_in=7, bmu_ap gorc; rsp_result=0x00FF00FF, rsp_error=0.
- Instr 0x00000000, tag=3 -> rsp_valid 1 cycle after accept with result=0, error=1, tag=3; bmu_valid_in never asserted.
- Legal op with rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; after the handshake, req_ready=1 next cycle.
- rst pulsed during WAIT -> next cycle rsp_valid=0, req_ready=1, bmu_valid_in=0; no response emitted for that tag.
